// File: rtl/calc_seq_controller.sv
// Keypad calculator sequencer: builds signed operands from digit strobes, dispatches to add/sub or multiplier, shows result.
// Optional build macro CALC_OVF_CHECK_EN routes signed add/sub overflow to the error state.
module calc_seq_controller #(
  parameter int WIDTH      = 16,
  parameter int MAX_DIGITS = 5,
  parameter int TIMEOUT    = 255
) (
  input  logic             clk,
  input  logic             nRST,
  input  logic             digit_valid,
  input  logic [3:0]       digit,
  input  logic             op_valid,
  input  logic [1:0]       op_code,
  input  logic             neg_toggle,
  input  logic             equal_input,
  input  logic             clear_input,
  output logic [WIDTH-1:0] arith_in1,
  output logic [WIDTH-1:0] arith_in2,
  output logic             add_sub,
  output logic             add_start,
  input  logic [WIDTH-1:0] add_out,
  input  logic             add_finish,
  output logic             mul_start,
  input  logic [WIDTH-1:0] mul_out,
  input  logic             mul_finish,
  output logic [WIDTH-1:0] display_output,
  output logic             complete,
  output logic             error
);
  // state    | meaning
  // ENTER_A  | collecting digits/sign of operand A
  // ENTER_B  | operator latched, collecting operand B
  // DISPATCH | one-cycle start pulse to the selected unit
  // WAIT     | waiting for the selected unit's finish, timer running
  // SHOW     | result displayed, complete high
  // ERR      | timeout or overflow, only clear/reset leaves
  typedef enum logic [2:0] {ENTER_A, ENTER_B, DISPATCH, WAIT, SHOW, ERR} state_t;

  localparam int CW = $clog2(MAX_DIGITS + 1);
  localparam int TW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0]    MAX_CNT  = CW'(MAX_DIGITS);
  localparam logic [TW-1:0]    TMO_LAST = TW'(TIMEOUT - 1);
  localparam logic [WIDTH+3:0] MAX_POS  = {5'b0, {(WIDTH-1){1'b1}}};
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b10;
  localparam logic [1:0] OP_RSV = 2'b11;

  state_t           state;
  logic [WIDTH-1:0] mag_a, mag_b;
  logic [CW-1:0]    cnt_a, cnt_b;
  logic             sign_a, sign_b;
  logic [1:0]       op;
  logic [TW-1:0]    timer;

  logic             in_b;
  logic [WIDTH-1:0] cur_mag;
  logic [CW-1:0]    cur_cnt;
  logic [WIDTH+3:0] mag_ext, mag_x10;
  logic [WIDTH-1:0] next_mag;
  logic             digit_legal, digit_ok, op_ok;
  logic [WIDTH-1:0] a_val, b_val, res_abs;
  logic             unit_finish, ovf;
  logic [WIDTH-1:0] unit_out;

  function automatic logic [WIDTH-1:0] signed_val(input logic neg, input logic [WIDTH-1:0] mag);
    return neg ? -mag : mag;
  endfunction

  assign in_b        = (state == ENTER_B);
  assign cur_mag     = in_b ? mag_b : mag_a;
  assign cur_cnt     = in_b ? cnt_b : cnt_a;
  assign mag_ext     = {4'b0, cur_mag};
  // x10 as shift-add; the 4 extra bits let the range check see values past the signed max
  assign mag_x10     = (mag_ext << 3) + (mag_ext << 1) + {{WIDTH{1'b0}}, digit};
  assign next_mag    = mag_x10[WIDTH-1:0];
  assign digit_legal = digit_valid && (digit <= 4'd9);
  assign digit_ok    = digit_legal && (cur_cnt < MAX_CNT) && (mag_x10 <= MAX_POS);
  assign op_ok       = op_valid && (op_code != OP_RSV);
  assign a_val       = signed_val(sign_a, mag_a);
  assign b_val       = signed_val(sign_b, mag_b);
  assign res_abs     = display_output[WIDTH-1] ? -display_output : display_output;
  assign unit_finish = (op == OP_MUL) ? mul_finish : add_finish;
  assign unit_out    = (op == OP_MUL) ? mul_out : add_out;

`ifdef CALC_OVF_CHECK_EN
  logic b_eff_sign;
  assign b_eff_sign = add_sub ? ~arith_in2[WIDTH-1] : arith_in2[WIDTH-1];
  assign ovf = (op != OP_MUL) && (arith_in1[WIDTH-1] == b_eff_sign)
               && (add_out[WIDTH-1] != arith_in1[WIDTH-1]);
`else
  assign ovf = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!nRST || clear_input) begin
      state          <= ENTER_A;
      mag_a          <= '0;
      mag_b          <= '0;
      cnt_a          <= '0;
      cnt_b          <= '0;
      sign_a         <= 1'b0;
      sign_b         <= 1'b0;
      op             <= '0;
      timer          <= '0;
      arith_in1      <= '0;
      arith_in2      <= '0;
      add_sub        <= 1'b0;
      add_start      <= 1'b0;
      mul_start      <= 1'b0;
      display_output <= '0;
      complete       <= 1'b0;
      error          <= 1'b0;
    end else begin
      add_start <= 1'b0;
      mul_start <= 1'b0;
      case (state)
        ENTER_A, ENTER_B: begin
          if (equal_input) begin
            if (in_b) begin
              arith_in1 <= a_val;
              arith_in2 <= b_val;
              add_sub   <= (op == OP_SUB);
              add_start <= (op != OP_MUL);
              mul_start <= (op == OP_MUL);
              state     <= DISPATCH;
            end
          end else if (op_ok) begin
            if (!in_b) begin
              op    <= op_code;
              state <= ENTER_B;
            end else if (cnt_b == '0) begin
              op <= op_code;
            end
          end else if (neg_toggle) begin
            if (in_b) begin
              sign_b         <= ~sign_b;
              display_output <= signed_val(~sign_b, mag_b);
            end else begin
              sign_a         <= ~sign_a;
              display_output <= signed_val(~sign_a, mag_a);
            end
          end else if (digit_ok) begin
            if (in_b) begin
              mag_b          <= next_mag;
              cnt_b          <= cnt_b + 1'b1;
              display_output <= signed_val(sign_b, next_mag);
            end else begin
              mag_a          <= next_mag;
              cnt_a          <= cnt_a + 1'b1;
              display_output <= signed_val(sign_a, next_mag);
            end
          end
        end
        DISPATCH: begin
          timer <= '0;
          state <= WAIT;
        end
        WAIT: begin
          if (unit_finish && ovf) begin
            error          <= 1'b1;
            display_output <= '0;
            state          <= ERR;
          end else if (unit_finish) begin
            display_output <= unit_out;
            complete       <= 1'b1;
            state          <= SHOW;
          end else if (timer == TMO_LAST) begin
            error          <= 1'b1;
            display_output <= '0;
            state          <= ERR;
          end else begin
            timer <= timer + 1'b1;
          end
        end
        SHOW: begin
          if (equal_input) begin
            sign_a    <= display_output[WIDTH-1];
            mag_a     <= res_abs;
            arith_in1 <= display_output;
            arith_in2 <= b_val;
            add_sub   <= (op == OP_SUB);
            add_start <= (op != OP_MUL);
            mul_start <= (op == OP_MUL);
            complete  <= 1'b0;
            state     <= DISPATCH;
          end else if (op_ok) begin
            sign_a   <= display_output[WIDTH-1];
            mag_a    <= res_abs;
            cnt_a    <= '0;
            mag_b    <= '0;
            cnt_b    <= '0;
            sign_b   <= 1'b0;
            op       <= op_code;
            complete <= 1'b0;
            state    <= ENTER_B;
          end else if (!neg_toggle && digit_legal) begin
            mag_a          <= {{(WIDTH-4){1'b0}}, digit};
            cnt_a          <= CW'(1);
            sign_a         <= 1'b0;
            mag_b          <= '0;
            cnt_b          <= '0;
            sign_b         <= 1'b0;
            op             <= '0;
            display_output <= {{(WIDTH-4){1'b0}}, digit};
            complete       <= 1'b0;
            state          <= ENTER_A;
          end
        end
        ERR: begin
          error          <= 1'b1;
          display_output <= '0;
          complete       <= 1'b0;
        end
        default: state <= ENTER_A;
      endcase
    end
  end
endmodule

// File: doc/calc_seq_controller.md
Name: calc_seq_controller

Overview:
- Parametrised successor to the keypad calculator controller.
- Builds signed operands from strobed keypad digits and latches an operator.
- Dispatches each operation to the shared add/sub unit or the multiplier over a start/finish handshake, then shows the result.
- Adds result chaining, sign entry, clear, a finish timeout and an error state; sits between keypad decode and the arithmetic units / display driver.

Parameters:
- WIDTH, 16, operand/result width, two's complement
- MAX_DIGITS, 5, max decimal digits accepted per operand
- TIMEOUT, 255, max cycles in WAIT before error

Ports:
- clk  in  1  system clock
- nRST  in  1  reset; one clock, reset synchronous, active-low
- digit_valid  in  1  one-cycle digit strobe
- digit  in  4  digit value 0-9; values >9 ignored
- op_valid  in  1  one-cycle operator strobe
- op_code  in  2  00 add, 01 sub, 10 mul, 11 reserved (strobe ignored)
- neg_toggle  in  1  one-cycle strobe, flips sign of operand being entered
- equal_input  in  1  one-cycle strobe, execute
- clear_input  in  1  one-cycle strobe, abort and return to reset state
- arith_in1  out  WIDTH  operand A to both units
- arith_in2  out  WIDTH  operand B to both units
- add_sub  out  1  0 add, 1 subtract
- add_start  out  1  one-cycle start to add/sub unit
- add_out  in  WIDTH  add/sub result
- add_finish  in  1  add/sub done
- mul_start  out  1  one-cycle start to multiplier
- mul_out  in  WIDTH  multiplier result
- mul_finish  in  1  multiplier done
- display_output  out  WIDTH  signed value shown
- complete  out  1  result valid
- error  out  1  timeout/overflow flag

Behaviour:
- Reset (nRST=0 at clk edge): state ENTER_A; all outputs 0; operands, digit counts, sign flags, op and timer 0.
- Strobe priority within one cycle: clear > equal > op > neg > digit; lower-priority strobes in the same cycle are dropped.
- States: ENTER_A, ENTER_B, DISPATCH, WAIT, SHOW, ERR.
- Digit entry, ENTER_A/ENTER_B: mag <= mag*10 + digit.
  - Ignored if digit count = MAX_DIGITS or new mag > 2^(WIDTH-1)-1.
  - Multiply by 10 done as (mag<<3)+(mag<<1).
- Operand value = sign ? -mag : mag.
- display_output tracks the operand being entered, registered, 1 cycle after the strobe.
- neg_toggle flips the sign of the current operand; allowed with zero digits.
- ENTER_A: op_valid latches op_code -> ENTER_B (zero digits = operand 0); display holds A.
- ENTER_B: op_valid with zero B digits replaces op; with digits entered, ignored. equal_input -> DISPATCH (zero digits = B is 0).
- DISPATCH, exactly 1 cycle:
  - arith_in1/arith_in2 hold A/B, stable through WAIT.
  - add_sub = (op==sub).
  - Exactly one of add_start/mul_start is high, selected by op.
  - -> WAIT.
- WAIT:
  - Only the selected unit's finish is honoured; any finish outside WAIT is ignored.
  - Timer counts from 0. On finish -> SHOW; display_output <= unit out; complete=1; both registered on the edge that samples finish.
  - If timer reaches TIMEOUT without finish -> ERR.
- SHOW: complete stays 1 and display holds the result until the next accepted strobe.
  - digit: fresh ENTER_A, result discarded, complete=0.
  - op: result becomes A (sign/magnitude recomputed), op latched -> ENTER_B, complete=0 (chaining).
  - neg: ignored.
  - equal: repeats the last op with the result as A and the same B -> DISPATCH.
- ERR: error=1, display_output=0, complete=0; only clear or reset leaves it.
- clear_input, any state including WAIT: next cycle equals the reset state. Starts stay 0 and the pending finish is ignored.
- Reset mid-WAIT: same as clear.

Optional Feature:
- Macro CALC_OVF_CHECK_EN.
- Defined: in WAIT, on add/sub finish, signed overflow is detected: result sign differs from A sign while A and effective B signs agree (B inverted for sub). On overflow -> ERR instead of SHOW. Multiplier results are never checked.
- Undefined: results pass through wrapped; error is raised only by timeout.

Test Plan:
- Digits 1,2,3, op add, digits 4,5, equal; unit returns 168 after 3 cycles -> exactly one add_start pulse; add_sub=0; arith_in1=123, arith_in2=45; display=168 and complete=1 one edge after add_finish.
- Digits 7, neg, op mul, digits 6; mul_out=-42 -> mul_start pulse only; arith_in1=0xFFF9; display=0xFFD6.
- Chain: result 168 showing, op sub, digit 8, equal; unit returns 160 -> add_sub=1, arith_in1=168, arith_in2=8, display=160.
- Digits 3,2,7,6,7 then 9 -> display=32767, sixth digit ignored. Digits 4,0,0,0,0 -> 4000; fifth digit ignored as 40000>32767.
- No finish for 255 cycles in WAIT -> error=1, display=0. clear -> all outputs 0 next cycle. clear asserted during WAIT with finish arriving the following cycle -> finish ignored, complete stays 0.
- CALC_OVF_CHECK_EN defined: 30000 + 10000, unit returns 0x9C40 -> error=1. Macro undefined: display=0x9C40, complete=1.
